softstart_and_qual: RTL and testbench

Parametrised, qualified AND gate for the step-down soft-start path: combines N enable conditions with a per-input mask and asserts its output only after all enabled conditions are true for QUAL_CYCLES consecutive clocks. An optional symmetric filter is also provided for the release direction. A `Tstate` test bypass forces a one-cycle registered pass-through. It replaces the fixed nand3/inv start gate in the soft-start sequencer, adding deglitching and status outputs.

---
 rtl/softstart_and_qual.sv | 131 +++++++++++++
 tb/tb_softstart_and_qual.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/softstart_and_qual.sv
// softstart_and_qual: masked N-input AND with assert qualification, optional
// release filtering and a registered test bypass for the soft-start path.
module softstart_and_qual #(
    parameter int unsigned N_IN        = 3,
    parameter int unsigned QUAL_CYCLES = 4,
    parameter int unsigned MODE        = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] i,
    input  logic [N_IN-1:0] mask,
    input  logic            Tstate,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            SUB,
    output logic            o,
    output logic            busy,
    output logic            rise_p
);

    localparam int unsigned CW = $clog2(QUAL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(QUAL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        QUAL = 2'd1,
        HIGH = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_IN-1:0] term_c;
    logic            raw_c;
    logic            o_n;
    logic            busy_n;

    // Supply/substrate pins exist only for netlist compatibility.
    logic unused_supply;
    assign unused_supply = CELV ^ CELG ^ SUB;

    // Masked AND; an all-zero mask never enables.
    assign term_c = i | ~mask;
    assign raw_c  = (|mask) & (&term_c);

    // Next state and counter; Tstate forces a plain registered pass-through.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (Tstate) begin
            state_n = raw_c ? HIGH : LOW;
            cnt_n   = '0;
        end else begin
            case (state)
                LOW: begin
                    cnt_n = '0;
                    if (raw_c) begin
                        if (QUAL_CYCLES == 1) begin
                            state_n = HIGH;
                        end else begin
                            state_n = QUAL;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                QUAL: begin
                    if (!raw_c) begin
                        state_n = LOW;
                        cnt_n   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    cnt_n = '0;
                    if (!raw_c) begin
                        if (MODE == 0 || QUAL_CYCLES == 1) begin
                            state_n = LOW;
                        end else begin
                            state_n = DROP;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                DROP: begin
                    if (raw_c) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = LOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n = LOW;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Output values that the registers will take at the next edge.
    always_comb begin
        o_n    = (state_n == HIGH) || (state_n == DROP);
        busy_n = (state_n == QUAL) || (state_n == DROP);
    end

    // State, counter and all outputs are registered; rst dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOW;
            cnt    <= '0;
            o      <= 1'b0;
            busy   <= 1'b0;
            rise_p <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            o      <= o_n;
            busy   <= busy_n;
            rise_p <= o_n & ~o;
        end
    end

endmodule

// File: tb/tb_softstart_and_qual.sv
// Bench for softstart_and_qual: three configurations driven in parallel,
// expected outputs queued at drive time and compared after each edge.
module tb_softstart_and_qual;

    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i;
    logic [N-1:0] mask;
    logic         Tstate;
    logic         celv = 1'b1;
    logic         celg = 1'b0;
    logic         sub  = 1'b0;
    logic [2:0]   o, busy, rise_p;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    softstart_and_qual #(.N_IN(N), .QUAL_CYCLES(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .i(i), .mask(mask), .Tstate(Tstate),
        .CELV(celv), .CELG(celg), .SUB(sub),
        .o(o[0]), .busy(busy[0]), .rise_p(rise_p[0]));

    softstart_and_qual #(.N_IN(N), .QUAL_CYCLES(4), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i(i), .mask(mask), .Tstate(Tstate),
        .CELV(celv), .CELG(celg), .SUB(sub),
        .o(o[1]), .busy(busy[1]), .rise_p(rise_p[1]));

    softstart_and_qual #(.N_IN(N), .QUAL_CYCLES(1), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .i(i), .mask(mask), .Tstate(Tstate),
        .CELV(celv), .CELG(celg), .SUB(sub),
        .o(o[2]), .busy(busy[2]), .rise_p(rise_p[2]));

    typedef struct packed {
        logic [2:0] o;
        logic [2:0] busy;
        logic [2:0] rise;
    } exp_t;

    exp_t sbq[$];

    int q_of[3]    = '{4, 4, 1};
    int mode_of[3] = '{0, 1, 0};
    int m_o[3]     = '{0, 0, 0};
    int m_run[3]   = '{0, 0, 0};

    task automatic check(input string tag, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int raw_model();
        int any_en = 0;
        for (int k = 0; k < int'(N); k++) begin
            if (mask[k]) begin
                any_en = 1;
                if (!i[k]) return 0;
            end
        end
        return any_en;
    endfunction

    // Model: run counts consecutive samples disagreeing with the current o.
    task automatic model_edge();
        exp_t e;
        int   r;
        int   prev;
        r = raw_model();
        for (int d = 0; d < 3; d++) begin
            prev = m_o[d];
            if (rst) begin
                m_o[d] = 0; m_run[d] = 0;
            end else if (Tstate) begin
                m_o[d] = r; m_run[d] = 0;
            end else if (m_o[d] == 0) begin
                if (r != 0) begin
                    m_run[d]++;
                    if (m_run[d] >= q_of[d]) begin m_o[d] = 1; m_run[d] = 0; end
                end else begin
                    m_run[d] = 0;
                end
            end else begin
                if (r == 0) begin
                    if (mode_of[d] == 0) begin
                        m_o[d] = 0; m_run[d] = 0;
                    end else begin
                        m_run[d]++;
                        if (m_run[d] >= q_of[d]) begin m_o[d] = 0; m_run[d] = 0; end
                    end
                end else begin
                    m_run[d] = 0;
                end
            end
            e.o[d]    = (m_o[d] != 0);
            e.busy[d] = (m_run[d] != 0);
            e.rise[d] = (m_o[d] != 0) && (prev == 0);
        end
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int s = 0; s < n; s++) begin
            model_edge();
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            for (int d = 0; d < 3; d++) begin
                check($sformatf("dut%0d_o", d),    o[d],      e.o[d]);
                check($sformatf("dut%0d_busy", d), busy[d],   e.busy[d]);
                check($sformatf("dut%0d_rise", d), rise_p[d], e.rise[d]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; i = '0; mask = 3'b111; Tstate = 1'b0;
        #2;
        step(2);
        check("reset_o", o[0], 1'b0);
        check("reset_busy", busy[0], 1'b0);

        // Reset and assert
        rst = 1'b0; i = 3'b111;
        step(3);
        check("assert_o_e3", o[0], 1'b0);
        check("assert_busy_e3", busy[0], 1'b1);
        check("q1_o", o[2], 1'b1);
        step(1);
        check("assert_o_e4", o[0], 1'b1);
        check("assert_rise_e4", rise_p[0], 1'b1);
        step(1);
        check("assert_rise_e5", rise_p[0], 1'b0);
        i = 3'b011;
        step(1);
        check("release_m0", o[0], 1'b0);
        check("release_m1_hold", o[1], 1'b1);

        // Glitch restart
        i = 3'b000; step(4);
        i = 3'b111; step(3);
        i = 3'b110; step(1);
        check("glitch_busy", busy[0], 1'b0);
        i = 3'b111; step(3);
        check("glitch_o_e3", o[0], 1'b0);
        step(1);
        check("glitch_o_e4", o[0], 1'b1);

        // Mask handling
        i = 3'b000; step(4);
        mask = 3'b101; i = 3'b101; step(4);
        check("mask101_o", o[0], 1'b1);
        mask = 3'b000; i = 3'b111; step(10);
        check("mask000_o", o[0], 1'b0);
        check("mask000_busy", busy[0], 1'b0);

        // MODE=1 release
        mask = 3'b111; i = 3'b111; step(5);
        check("m1_high", o[1], 1'b1);
        i = 3'b000; step(3);
        check("m1_dip_o", o[1], 1'b1);
        i = 3'b111; step(1);
        check("m1_back_o", o[1], 1'b1);
        check("m1_back_rise", rise_p[1], 1'b0);
        i = 3'b000; step(3);
        check("m1_drop3", o[1], 1'b1);
        step(1);
        check("m1_drop4", o[1], 1'b0);

        // Tstate bypass
        Tstate = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i = (k % 2 == 1) ? 3'b111 : 3'b000;
            step(1);
            check("tstate_o", o[0], (k % 2 == 1));
            check("tstate_busy", busy[1], 1'b0);
        end
        Tstate = 1'b0; i = 3'b111;
        step(2);
        check("tstate_exit_hold", o[0], 1'b1);

        // Reset mid-count
        i = 3'b000; step(4);
        i = 3'b111; step(2);
        rst = 1'b1; step(1);
        check("midrst_o", o[0], 1'b0);
        rst = 1'b0; step(3);
        check("midrst_recount3", o[0], 1'b0);
        step(1);
        check("midrst_recount4", o[0], 1'b1);

        // Random soak
        for (int k = 0; k < 300; k++) begin
            i      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) i = 3'b111;
            mask   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            Tstate = ($urandom_range(0, 15) == 0);
            rst    = ($urandom_range(0, 40) == 0);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
